// File: rtl/sr04_pkg.sv
// Shared types and constants for the SR04 round-robin scheduler.
// Holds the scheduler FSM state encoding, the measurement width and the miss-counter limits.
package sr04_pkg;

  localparam int MEAS_W = 32;
  localparam int MISS_W = 16;
  localparam logic [MISS_W-1:0] MISS_SAT = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_START,
    ST_MEASURE,
    ST_REPORT,
    ST_HOLDOFF
  } state_e;

endpackage

// File: rtl/sr04_rr_pick.sv
// Combinational round-robin picker: finds the first set mask bit strictly after last_ch, wrapping,
// so that last_ch itself is only chosen again when it is the sole enabled channel.
module sr04_rr_pick
  import sr04_pkg::*;
#(
  parameter int NUM_SENSORS = 4,
  parameter int CH_W        = $clog2(NUM_SENSORS)
) (
  input  logic [NUM_SENSORS-1:0] mask,
  input  logic [CH_W-1:0]        last_ch,
  output logic [CH_W-1:0]        next_ch,
  output logic                   any_valid
);

  logic [CH_W-1:0] idx;

  // Scan from the farthest offset down to the nearest so the closest hit is written last and wins.
  always_comb begin
    next_ch   = '0;
    any_valid = 1'b0;
    idx       = '0;
    for (int k = NUM_SENSORS; k >= 1; k--) begin
      idx = CH_W'((int'(last_ch) + k) % NUM_SENSORS);
      if (mask[idx]) begin
        next_ch   = idx;
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sr04_scheduler.sv
// Round-robin scheduler sharing one SR04 ranging engine across NUM_SENSORS sensors.
// Optional SR04_SCHED_STATS_EN adds a saturating miss_count output of timed-out slots.
module sr04_scheduler
  import sr04_pkg::*;
#(
  parameter int NUM_SENSORS    = 4,
  parameter int SLOT_CYCLES    = 40000,
  parameter int HOLDOFF_CYCLES = 16000,
  parameter int CH_W           = $clog2(NUM_SENSORS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   run,
  input  logic [NUM_SENSORS-1:0] ch_mask,
  output logic [NUM_SENSORS-1:0] sensor_trigger_out,
  input  logic [NUM_SENSORS-1:0] sensor_echo_in,
  output logic                   eng_en,
  input  logic                   eng_trigger_in,
  output logic                   eng_echo_out,
  input  logic [MEAS_W-1:0]      eng_value,
  input  logic                   eng_value_ok,
  output logic                   result_valid,
  output logic [CH_W-1:0]        result_ch,
  output logic [MEAS_W-1:0]      result_value,
  output logic                   result_timeout,
  output logic                   busy
`ifdef SR04_SCHED_STATS_EN
  ,
  output logic [MISS_W-1:0]      miss_count
`endif
);

  if (SLOT_CYCLES <= 0) begin : g_bad_slot
    $error("sr04_scheduler: SLOT_CYCLES must be nonzero");
  end
  if (HOLDOFF_CYCLES <= 0) begin : g_bad_holdoff
    $error("sr04_scheduler: HOLDOFF_CYCLES must be nonzero");
  end
  if (NUM_SENSORS < 2 || NUM_SENSORS > 16) begin : g_bad_num
    $error("sr04_scheduler: NUM_SENSORS must be in 2..16");
  end

  localparam logic [31:0] SLOT_LAST = 32'(SLOT_CYCLES - 1);
  localparam logic [31:0] HOLD_LAST = 32'(HOLDOFF_CYCLES - 1);

  state_e             state_q, state_d;
  logic [CH_W-1:0]    sel_ch_q, sel_ch_d;
  logic [CH_W-1:0]    last_ch_q, last_ch_d;
  logic [31:0]        slot_cnt_q, slot_cnt_d;
  logic [31:0]        hold_cnt_q, hold_cnt_d;
  logic [MEAS_W-1:0]  cap_value_q, cap_value_d;
  logic               seen_ok_q, seen_ok_d;
  logic               res_valid_q, res_valid_d;
  logic [CH_W-1:0]    res_ch_q, res_ch_d;
  logic [MEAS_W-1:0]  res_value_q, res_value_d;
  logic               res_timeout_q, res_timeout_d;

  logic [CH_W-1:0]    pick_ch;
  logic               pick_valid;

  sr04_rr_pick #(
    .NUM_SENSORS (NUM_SENSORS),
    .CH_W        (CH_W)
  ) u_pick (
    .mask      (ch_mask),
    .last_ch   (last_ch_q),
    .next_ch   (pick_ch),
    .any_valid (pick_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      sel_ch_q      <= '0;
      last_ch_q     <= CH_W'(NUM_SENSORS - 1);
      slot_cnt_q    <= '0;
      hold_cnt_q    <= '0;
      cap_value_q   <= '0;
      seen_ok_q     <= 1'b0;
      res_valid_q   <= 1'b0;
      res_ch_q      <= '0;
      res_value_q   <= '0;
      res_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sel_ch_q      <= sel_ch_d;
      last_ch_q     <= last_ch_d;
      slot_cnt_q    <= slot_cnt_d;
      hold_cnt_q    <= hold_cnt_d;
      cap_value_q   <= cap_value_d;
      seen_ok_q     <= seen_ok_d;
      res_valid_q   <= res_valid_d;
      res_ch_q      <= res_ch_d;
      res_value_q   <= res_value_d;
      res_timeout_q <= res_timeout_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    sel_ch_d      = sel_ch_q;
    last_ch_d     = last_ch_q;
    slot_cnt_d    = slot_cnt_q;
    hold_cnt_d    = hold_cnt_q;
    cap_value_d   = cap_value_q;
    seen_ok_d     = seen_ok_q;
    res_valid_d   = 1'b0;
    res_ch_d      = res_ch_q;
    res_value_d   = res_value_q;
    res_timeout_d = res_timeout_q;

    case (state_q)
      ST_IDLE: begin
        if (run && (|ch_mask)) state_d = ST_SELECT;
      end
      ST_SELECT: begin
        if (pick_valid) begin
          sel_ch_d = pick_ch;
          state_d  = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        slot_cnt_d  = '0;
        cap_value_d = '0;
        seen_ok_d   = 1'b0;
        state_d     = ST_MEASURE;
      end
      ST_MEASURE: begin
        slot_cnt_d = slot_cnt_q + 32'd1;
        if (eng_value_ok) begin
          cap_value_d = eng_value;
          seen_ok_d   = 1'b1;
        end
        // Result registers load on the final measure cycle so they are already valid during REPORT.
        if (slot_cnt_q == SLOT_LAST) begin
          state_d       = ST_REPORT;
          res_valid_d   = 1'b1;
          res_ch_d      = sel_ch_q;
          res_timeout_d = !seen_ok_d;
          res_value_d   = seen_ok_d ? cap_value_d : '0;
        end
      end
      ST_REPORT: begin
        last_ch_d  = sel_ch_q;
        hold_cnt_d = '0;
        state_d    = run ? ST_HOLDOFF : ST_IDLE;
      end
      ST_HOLDOFF: begin
        if (!run) begin
          state_d = ST_IDLE;
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d = ST_SELECT;
        end else begin
          hold_cnt_d = hold_cnt_q + 32'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    sensor_trigger_out = '0;
    eng_echo_out       = 1'b0;
    if (state_q == ST_START || state_q == ST_MEASURE) begin
      sensor_trigger_out[sel_ch_q] = eng_trigger_in;
      eng_echo_out                 = sensor_echo_in[sel_ch_q];
    end
  end

  assign eng_en         = (state_q == ST_START);
  assign busy           = (state_q != ST_IDLE);
  assign result_valid   = res_valid_q;
  assign result_ch      = res_ch_q;
  assign result_value   = res_value_q;
  assign result_timeout = res_timeout_q;

`ifdef SR04_SCHED_STATS_EN
  logic [MISS_W-1:0] miss_q, miss_d;

  always_ff @(posedge clk) begin
    if (reset) miss_q <= '0;
    else       miss_q <= miss_d;
  end

  always_comb begin
    miss_d = miss_q;
    if (res_valid_q && res_timeout_q && (miss_q != MISS_SAT)) miss_d = miss_q + 1'b1;
  end

  assign miss_count = miss_q;
`endif

endmodule
